// File: rtl/cdec_dp_gen.sv
// CDEC data path: single XBUS register transfer, parametrised width and GPR count,
// with a handshaked memory port that aborts after MEM_TIMEOUT wait cycles.
module cdec_dp_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NGPR        = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [13:0]      ctrl,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_cy,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [2:0]       alu_flag,
  output logic [WIDTH-1:0] I,
  output logic [2:0]       SZCy,
  output logic             mem_busy,
  output logic             mem_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adrs,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  input  logic [7:0]       resad,
  output logic [WIDTH-1:0] resdt
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRd = 2'd1, StWr = 2'd2} mem_state_e;

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);
  localparam logic [3:0] NgprW       = 4'(NGPR);

  logic [1:0] mmrw;
  logic       fwr, rwr, errclr, unused_rsv;
  logic [3:0] xdst, xsrc;
  assign {mmrw, fwr, rwr, xdst, xsrc, errclr, unused_rsv} = ctrl;

  logic [WIDTH-1:0] pc_q, i_q, t_q, r_q, mar_q, wdr_q, rdr_q, iport_q, oport_q;
  logic [WIDTH-1:0] adrs_q, wdata_q;
  logic [WIDTH-1:0] gpr_q [8];
  logic [2:0]       szcy_q;
  logic             err_q;
  logic [7:0]       cnt_q;
  mem_state_e       state_q;

  logic [WIDTH-1:0] flg, xbus;
  logic             src_gpr, dst_gpr;

  assign src_gpr = xsrc[3] && ({1'b0, xsrc[2:0]} < NgprW);
  assign dst_gpr = xdst[3] && ({1'b0, xdst[2:0]} < NgprW);

  always_comb begin
    flg      = '0;
    flg[4]   = err_q;
    flg[3:1] = szcy_q;
  end

  // Unassigned source codes read as all-ones, like an undriven pulled-up bus.
  always_comb begin
    xbus = '1;
    case (xsrc)
      4'd0:    xbus = pc_q;
      4'd1:    xbus = r_q;
      4'd2:    xbus = rdr_q;
      4'd3:    xbus = flg;
      4'd4:    xbus = iport_q;
      4'd5:    xbus = '1;
      4'd6:    xbus = t_q;
      4'd7:    xbus = i_q;
      default: if (src_gpr) xbus = gpr_q[xsrc[2:0]];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      i_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      mar_q   <= '0;
      wdr_q   <= '0;
      rdr_q   <= '0;
      iport_q <= '0;
      oport_q <= '0;
      adrs_q  <= '0;
      wdata_q <= '0;
      szcy_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= StIdle;
      for (int k = 0; k < 8; k++) gpr_q[k] <= '0;
    end else begin
      iport_q <= io_in;
      if (rwr) r_q <= alu_result;
      if (fwr) szcy_q <= alu_flag;
      if (errclr) err_q <= 1'b0;

      case (xdst)
        4'd0:    pc_q <= xbus;
        4'd1:    i_q <= xbus;
        4'd2:    t_q <= xbus;
        4'd3:    mar_q <= xbus;
        4'd4:    wdr_q <= xbus;
        4'd5:    oport_q <= xbus;
        default: if (dst_gpr) gpr_q[xdst[2:0]] <= xbus;
      endcase

      // Address/data are latched from the pre-edge MAR/WDR, so a same-cycle MAR write
      // only affects the next transaction.
      case (state_q)
        StIdle: begin
          if (mmrw == 2'b10) begin
            adrs_q  <= mar_q;
            cnt_q   <= '0;
            state_q <= StRd;
          end else if (mmrw == 2'b01) begin
            adrs_q  <= mar_q;
            wdata_q <= wdr_q;
            cnt_q   <= '0;
            state_q <= StWr;
          end
        end
        StRd, StWr: begin
          if (mem_ack) begin
            if (state_q == StRd) rdr_q <= mem_rdata;
            state_q <= StIdle;
          end else if (cnt_q == TimeoutLast) begin
            err_q <= 1'b1;
            if (state_q == StRd) rdr_q <= '1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    resdt = '0;
    case (resad)
      8'h00: resdt = pc_q;
      8'h01: resdt = i_q;
      8'h02: resdt = t_q;
      8'h03: resdt = r_q;
      8'h04: resdt = mar_q;
      8'h05: resdt = mem_rdata;
      8'h06: resdt = rdr_q;
      8'h07: resdt = wdr_q;
      8'h08: resdt = flg;
      8'h09: resdt = xbus;
      8'h0A: resdt = iport_q;
      8'h0B: resdt[1:0] = state_q;
      8'h0C: resdt[7:0] = cnt_q;
      default: begin
        if (resad[7:3] == 5'b00010 && ({1'b0, resad[2:0]} < NgprW)) resdt = gpr_q[resad[2:0]];
      end
    endcase
  end

  assign alu_x     = xbus;
  assign alu_y     = t_q;
  assign alu_cy    = szcy_q[0];
  assign I         = i_q;
  assign SZCy      = szcy_q;
  assign mem_err   = err_q;
  assign mem_busy  = (state_q != StIdle);
  assign mem_req   = (state_q != StIdle);
  assign mem_we    = (state_q == StWr);
  assign mem_adrs  = adrs_q;
  assign mem_wdata = wdata_q;
  assign io_out    = oport_q;

endmodule

// File: tb/tb_cdec_dp_gen.sv
// Bench for cdec_dp_gen: 16-bit register-move table, 8-bit memory/ALU sequences,
// and randomized traffic against a transaction-level model.
module tb_cdec_dp_gen;

  localparam int unsigned ATo = 4;
  localparam logic [13:0] CtrlIdle = {2'b00, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0, 1'b0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [13:0] a_ctrl;
  logic [7:0]  a_alu_x, a_alu_y, a_alu_result, a_I, a_mem_adrs, a_mem_wdata, a_mem_rdata;
  logic [7:0]  a_io_in, a_io_out, a_resad, a_resdt;
  logic [2:0]  a_alu_flag, a_SZCy;
  logic        a_alu_cy, a_mem_busy, a_mem_err, a_mem_req, a_mem_we, a_mem_ack;

  logic [13:0] b_ctrl;
  logic [15:0] b_alu_x, b_alu_y, b_alu_result, b_I, b_mem_adrs, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_io_in, b_io_out, b_resdt;
  logic [7:0]  b_resad;
  logic [2:0]  b_alu_flag, b_SZCy;
  logic        b_alu_cy, b_mem_busy, b_mem_err, b_mem_req, b_mem_we, b_mem_ack;

  cdec_dp_gen #(.WIDTH(8), .NGPR(3), .MEM_TIMEOUT(ATo)) dut_a (
    .clock(clock), .reset(reset), .ctrl(a_ctrl), .alu_x(a_alu_x), .alu_y(a_alu_y),
    .alu_cy(a_alu_cy), .alu_result(a_alu_result), .alu_flag(a_alu_flag), .I(a_I),
    .SZCy(a_SZCy), .mem_busy(a_mem_busy), .mem_err(a_mem_err), .mem_req(a_mem_req),
    .mem_we(a_mem_we), .mem_adrs(a_mem_adrs), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack), .io_in(a_io_in), .io_out(a_io_out),
    .resad(a_resad), .resdt(a_resdt)
  );

  cdec_dp_gen #(.WIDTH(16), .NGPR(4), .MEM_TIMEOUT(15)) dut_b (
    .clock(clock), .reset(reset), .ctrl(b_ctrl), .alu_x(b_alu_x), .alu_y(b_alu_y),
    .alu_cy(b_alu_cy), .alu_result(b_alu_result), .alu_flag(b_alu_flag), .I(b_I),
    .SZCy(b_SZCy), .mem_busy(b_mem_busy), .mem_err(b_mem_err), .mem_req(b_mem_req),
    .mem_we(b_mem_we), .mem_adrs(b_mem_adrs), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack), .io_in(b_io_in), .io_out(b_io_out),
    .resad(b_resad), .resdt(b_resdt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic [1:0] mmrw, input logic fwr, input logic rwr,
                                     input logic [3:0] xdst, input logic [3:0] xsrc,
                                     input logic errclr);
    return {mmrw, fwr, rwr, xdst, xsrc, errclr, 1'b0};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic a_idle();
    a_ctrl = CtrlIdle; a_alu_result = '0; a_alu_flag = '0; a_mem_rdata = '0;
    a_mem_ack = 1'b0; a_io_in = '0; a_resad = '0;
  endtask

  task automatic do_reset();
    a_idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Put val on a destination by way of R.
  task automatic a_load(input logic [3:0] dst, input logic [7:0] val);
    a_alu_result = val;
    a_ctrl = mk(2'b00, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0);
    cyc();
    a_ctrl = mk(2'b00, 1'b0, 1'b0, dst, 4'd1, 1'b0);
    cyc();
    a_ctrl = CtrlIdle;
  endtask

  // Reference model of dut_a: architectural registers plus an outstanding-transaction record.
  logic [7:0] m_pc, m_i, m_t, m_r, m_mar, m_wdr, m_rdr, m_iport, m_oport, m_adrs, m_wdata;
  logic [7:0] m_g [3];
  logic [2:0] m_szcy;
  logic       m_err;
  int         m_pend;  // 0 none, 1 read, 2 write
  int         m_age;   // wait cycles elapsed without ack

  function automatic logic [7:0] m_xbus(input logic [3:0] src);
    case (src)
      4'd0: return m_pc;
      4'd1: return m_r;
      4'd2: return m_rdr;
      4'd3: return {3'b000, m_err, m_szcy, 1'b0};
      4'd4: return m_iport;
      4'd6: return m_t;
      4'd7: return m_i;
      default: if (int'(src) >= 8 && int'(src) < 11) return m_g[int'(src) - 8];
    endcase
    return 8'hFF;
  endfunction

  function automatic logic [7:0] m_res(input logic [7:0] ad, input logic [3:0] src,
                                       input logic [7:0] rdata);
    if (int'(ad) >= 16 && int'(ad) < 19) return m_g[int'(ad) - 16];
    case (ad)
      8'h00: return m_pc;
      8'h01: return m_i;
      8'h02: return m_t;
      8'h03: return m_r;
      8'h04: return m_mar;
      8'h05: return rdata;
      8'h06: return m_rdr;
      8'h07: return m_wdr;
      8'h08: return {3'b000, m_err, m_szcy, 1'b0};
      8'h09: return m_xbus(src);
      8'h0A: return m_iport;
      8'h0B: return 8'(m_pend);
      8'h0C: return 8'(m_age);
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_init();
    m_pc = 0; m_i = 0; m_t = 0; m_r = 0; m_mar = 0; m_wdr = 0; m_rdr = 0; m_iport = 0;
    m_oport = 0; m_adrs = 0; m_wdata = 0; m_szcy = 0; m_err = 0; m_pend = 0; m_age = 0;
    for (int k = 0; k < 3; k++) m_g[k] = 0;
  endtask

  task automatic m_step(input logic [13:0] c, input logic [7:0] res, input logic [2:0] flag,
                        input logic [7:0] rdata, input logic ack, input logic [7:0] din);
    logic [7:0] xb;
    xb = m_xbus(c[5:2]);
    if (c[1]) m_err = 1'b0;
    if (m_pend == 0) begin
      if (c[13:12] == 2'b10) begin
        m_pend = 1; m_age = 0; m_adrs = m_mar;
      end else if (c[13:12] == 2'b01) begin
        m_pend = 2; m_age = 0; m_adrs = m_mar; m_wdata = m_wdr;
      end
    end else if (ack) begin
      if (m_pend == 1) m_rdr = rdata;
      m_pend = 0;
    end else if (m_age + 1 == int'(ATo)) begin
      if (m_pend == 1) m_rdr = 8'hFF;
      m_err = 1'b1;
      m_pend = 0;
    end else begin
      m_age = m_age + 1;
    end
    if (c[10]) m_r = res;
    if (c[11]) m_szcy = flag;
    m_iport = din;
    case (int'(c[9:6]))
      0: m_pc = xb;
      1: m_i = xb;
      2: m_t = xb;
      3: m_mar = xb;
      4: m_wdr = xb;
      5: m_oport = xb;
      8, 9, 10: m_g[int'(c[9:6]) - 8] = xb;
      default: ;
    endcase
  endtask

  typedef struct packed {
    logic [3:0]  xsrc;
    logic [3:0]  xdst;
    logic [7:0]  resad;
    logic [15:0] exp_x;
    logic [15:0] exp_res;
    logic [15:0] exp_io;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [13:0] c;

    tbl[0]  = '{4'd5,  4'd8,  8'h00, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[1]  = '{4'd8,  4'd11, 8'h10, 16'hFFFF, 16'hFFFF, 16'h0000};
    tbl[2]  = '{4'd12, 4'd6,  8'h13, 16'hFFFF, 16'hFFFF, 16'h0000};
    tbl[3]  = '{4'd0,  4'd2,  8'h14, 16'h0000, 16'h0000, 16'h0000};
    tbl[4]  = '{4'd11, 4'd0,  8'h02, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[5]  = '{4'd4,  4'd1,  8'h00, 16'h1234, 16'hFFFF, 16'h0000};
    tbl[6]  = '{4'd15, 4'd13, 8'h01, 16'hFFFF, 16'h1234, 16'h0000};
    tbl[7]  = '{4'd7,  4'd5,  8'h0B, 16'h1234, 16'h0000, 16'h0000};
    tbl[8]  = '{4'd4,  4'd9,  8'h0A, 16'h1234, 16'h1234, 16'h1234};
    tbl[9]  = '{4'd9,  4'd7,  8'h11, 16'h1234, 16'h1234, 16'h1234};
    tbl[10] = '{4'd13, 4'd7,  8'h0D, 16'hFFFF, 16'h0000, 16'h1234};
    tbl[11] = '{4'd10, 4'd6,  8'h12, 16'h0000, 16'h0000, 16'h1234};

    b_ctrl = CtrlIdle; b_alu_result = '0; b_alu_flag = '0; b_mem_rdata = '0;
    b_mem_ack = 1'b0; b_io_in = 16'h1234; b_resad = '0;
    do_reset();

    // Reset state
    chk("rst_req", 32'(a_mem_req), 0);
    chk("rst_we", 32'(a_mem_we), 0);
    chk("rst_busy", 32'(a_mem_busy), 0);
    chk("rst_err", 32'(a_mem_err), 0);
    chk("rst_I", 32'(a_I), 0);
    chk("rst_adrs", 32'(a_mem_adrs), 0);
    chk("rst_b_busy", 32'(b_mem_busy), 0);
    chk("rst_b_pc", 32'(b_resdt), 0);

    // 16-bit register-move table
    for (int k = 0; k < 12; k++) begin
      b_ctrl = mk(2'b00, 1'b0, 1'b0, tbl[k].xdst, tbl[k].xsrc, 1'b0);
      b_resad = tbl[k].resad;
      #1;
      chk($sformatf("tbl%0d_x", k), 32'(b_alu_x), 32'(tbl[k].exp_x));
      chk($sformatf("tbl%0d_res", k), 32'(b_resdt), 32'(tbl[k].exp_res));
      chk($sformatf("tbl%0d_io", k), 32'(b_io_out), 32'(tbl[k].exp_io));
      cyc();
    end
    b_ctrl = CtrlIdle;

    // ALU path
    do_reset();
    a_load(4'd2, 8'h01);
    a_alu_result = 8'h7F;
    a_ctrl = mk(2'b00, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0);
    cyc();
    a_ctrl = mk(2'b00, 1'b1, 1'b1, 4'd6, 4'd1, 1'b0);
    a_alu_result = 8'h80; a_alu_flag = 3'b100;
    #1;
    chk("alu_x", 32'(a_alu_x), 32'h7F);
    chk("alu_y", 32'(a_alu_y), 32'h01);
    cyc();
    a_ctrl = CtrlIdle; a_resad = 8'h03;
    #1;
    chk("alu_r", 32'(a_resdt), 32'h80);
    chk("alu_szcy", 32'(a_SZCy), 32'b100);
    chk("alu_cy0", 32'(a_alu_cy), 0);
    a_resad = 8'h08;
    #1;
    chk("alu_flg", 32'(a_resdt), 32'h08);
    a_ctrl = mk(2'b00, 1'b1, 1'b0, 4'd6, 4'd0, 1'b0); a_alu_flag = 3'b001;
    cyc();
    a_ctrl = CtrlIdle;
    #1;
    chk("alu_cy1", 32'(a_alu_cy), 1);
    chk("alu_flg_cy", 32'(a_resdt), 32'h02);

    // Read with ack on the third cycle after issue
    do_reset();
    a_load(4'd3, 8'h40);
    a_ctrl = mk(2'b10, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0);
    cyc();
    n = 0;
    for (int c3 = 1; c3 <= 3; c3++) begin
      a_ctrl = mk(2'b00, 1'b0, 1'b0, 4'd6, 4'd2, 1'b0);
      a_mem_ack = (c3 == 3);
      a_mem_rdata = (c3 == 3) ? 8'h5A : 8'hEE;
      #1;
      if (a_mem_req) n++;
      if (c3 == 1) begin
        chk("rd_adrs", 32'(a_mem_adrs), 32'h40);
        chk("rd_we", 32'(a_mem_we), 0);
        chk("rd_old_rdr", 32'(a_alu_x), 0);
      end
      cyc();
    end
    a_mem_ack = 1'b0; a_ctrl = CtrlIdle; a_resad = 8'h06;
    #1;
    chk("rd_req_cycles", 32'(n), 3);
    chk("rd_busy_after", 32'(a_mem_busy), 0);
    chk("rd_rdr", 32'(a_resdt), 32'h5A);

    // Write issued alongside a MAR write; a read request during WR is dropped
    do_reset();
    a_load(4'd3, 8'h10);
    a_load(4'd4, 8'h3C);
    a_alu_result = 8'h99;
    a_ctrl = mk(2'b00, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0);
    cyc();
    a_ctrl = mk(2'b01, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0);
    cyc();
    a_ctrl = mk(2'b10, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0); a_resad = 8'h04;
    #1;
    chk("wr_adrs", 32'(a_mem_adrs), 32'h10);
    chk("wr_wdata", 32'(a_mem_wdata), 32'h3C);
    chk("wr_we", 32'(a_mem_we), 1);
    chk("wr_mar_new", 32'(a_resdt), 32'h99);
    cyc();
    a_ctrl = CtrlIdle; a_resad = 8'h0B;
    #1;
    chk("wr_still_we", 32'(a_mem_we), 1);
    chk("wr_state", 32'(a_resdt), 2);
    a_mem_ack = 1'b1;
    cyc();
    a_mem_ack = 1'b0;
    #1;
    chk("wr_done_busy", 32'(a_mem_busy), 0);
    cyc();
    chk("wr_no_queue", 32'(a_mem_req), 0);

    // Timeout abort, error clear, and set-wins on the abort cycle
    do_reset();
    a_ctrl = mk(2'b10, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0);
    cyc();
    a_ctrl = CtrlIdle;
    n = 0;
    while (a_mem_req && n < 20) begin
      n++;
      cyc();
    end
    chk("to_req_cycles", 32'(n), 4);
    a_resad = 8'h06;
    #1;
    chk("to_rdr", 32'(a_resdt), 32'hFF);
    chk("to_err", 32'(a_mem_err), 1);
    a_resad = 8'h08;
    #1;
    chk("to_flg", 32'(a_resdt), 32'h10);
    a_ctrl = mk(2'b00, 1'b0, 1'b0, 4'd6, 4'd0, 1'b1);
    cyc();
    a_ctrl = CtrlIdle;
    #1;
    chk("clr_flg", 32'(a_resdt), 32'h00);
    a_ctrl = mk(2'b10, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0);
    cyc();
    a_ctrl = CtrlIdle;
    repeat (3) cyc();
    a_ctrl = mk(2'b00, 1'b0, 1'b0, 4'd6, 4'd0, 1'b1);
    #1;
    chk("setwin_req_pre", 32'(a_mem_req), 1);
    cyc();
    a_ctrl = CtrlIdle;
    #1;
    chk("setwin_req", 32'(a_mem_req), 0);
    chk("setwin_err", 32'(a_mem_err), 1);

    // Reset while a read waits for its ack (RDR currently holds FF from the abort)
    a_ctrl = mk(2'b10, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0);
    cyc();
    a_ctrl = CtrlIdle;
    reset = 1'b1; a_mem_ack = 1'b1; a_mem_rdata = 8'h77;
    cyc();
    reset = 1'b0; a_mem_ack = 1'b0; a_resad = 8'h0B;
    #1;
    chk("rstrd_req", 32'(a_mem_req), 0);
    chk("rstrd_state", 32'(a_resdt), 0);
    a_resad = 8'h06;
    #1;
    chk("rstrd_rdr", 32'(a_resdt), 0);
    a_mem_ack = 1'b1;
    cyc();
    a_mem_ack = 1'b0;
    #1;
    chk("late_ack_rdr", 32'(a_resdt), 0);
    chk("late_ack_req", 32'(a_mem_req), 0);

    // Randomized traffic against the model
    do_reset();
    m_init();
    for (int it = 0; it < 600; it++) begin
      c = 14'($urandom);
      if ($urandom_range(0, 3) != 0) c[1] = 1'b0;
      a_ctrl = c;
      a_alu_result = 8'($urandom);
      a_alu_flag = 3'($urandom);
      a_mem_rdata = 8'($urandom);
      a_mem_ack = ($urandom_range(0, 2) == 0);
      a_io_in = 8'($urandom);
      a_resad = 8'($urandom_range(0, 20));
      #1;
      chk("rnd_x", 32'(a_alu_x), 32'(m_xbus(c[5:2])));
      if (!(a_resad == 8'h0C && m_pend == 0))
        chk("rnd_res", 32'(a_resdt), 32'(m_res(a_resad, c[5:2], a_mem_rdata)));
      chk("rnd_req", 32'(a_mem_req), 32'(m_pend != 0));
      chk("rnd_we", 32'(a_mem_we), 32'(m_pend == 2));
      chk("rnd_busy", 32'(a_mem_busy), 32'(m_pend != 0));
      chk("rnd_err", 32'(a_mem_err), 32'(m_err));
      chk("rnd_szcy", 32'(a_SZCy), 32'(m_szcy));
      chk("rnd_cy", 32'(a_alu_cy), 32'(m_szcy[0]));
      chk("rnd_I", 32'(a_I), 32'(m_i));
      chk("rnd_y", 32'(a_alu_y), 32'(m_t));
      chk("rnd_io", 32'(a_io_out), 32'(m_oport));
      if (m_pend != 0) chk("rnd_adrs", 32'(a_mem_adrs), 32'(m_adrs));
      if (m_pend == 2) chk("rnd_wdata", 32'(a_mem_wdata), 32'(m_wdata));
      m_step(c, a_alu_result, a_alu_flag, a_mem_rdata, a_mem_ack, a_io_in);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdec_dp_gen.md
Name: cdec_dp_gen

Overview:
Parametrised next-generation CDEC data path. It keeps the single-XBUS register-transfer organisation and adds three things: configurable word width, a configurable number of general-purpose registers, and a handshaked, multi-cycle memory interface with timeout. The ALU stays external, so the same data path serves 8/16-bit CDEC variants. The block sits between the control unit (ctrl in; I, SZCy, mem_busy out) and the memory/IO/debug-monitor fabric.

Parameters:
WIDTH, 8, data/address word width (8..32)
NGPR, 3, number of general registers G0..G(NGPR-1) (1..8)
MEM_TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
ctrl  in  14  {mmrw[1:0], fwr, rwr, xdst[3:0], xsrc[3:0], errclr, rsv}; rsv ignored
alu_x  out  WIDTH  XBUS value to ALU x input
alu_y  out  WIDTH  T register to ALU y input
alu_cy  out  1  FLG carry bit to ALU
alu_result  in  WIDTH  ALU result
alu_flag  in  3  ALU {S,Z,Cy}
I  out  WIDTH  instruction register
SZCy  out  3  FLG[3:1]
mem_busy  out  1  memory FSM not IDLE
mem_err  out  1  sticky memory-timeout flag (= FLG[4])
mem_req  out  1  memory request, held until ack/abort
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_adrs  out  WIDTH  address captured at issue
mem_wdata  out  WIDTH  write data captured at issue
mem_rdata  in  WIDTH  read data, valid when mem_ack
mem_ack  in  1  one-cycle completion strobe
io_in  in  WIDTH  input port
io_out  out  WIDTH  output port register
resad  in  8  debug-monitor resource address
resdt  out  WIDTH  debug-monitor resource data

Behaviour:
- Reset: every register (PC, I, T, R, MAR, WDR, RDR, FLG, IPORT, OPORT, all Gk), mem_adrs, mem_wdata, and the timeout counter go to 0. FSM goes to IDLE, so mem_req=mem_we=mem_busy=0. Reset mid-transaction drops mem_req on that edge and leaves RDR unchanged (0).
- XBUS source by xsrc: 0 PC, 1 R, 2 RDR, 3 FLG, 4 IPORT, 5 all-ones, 6 T, 7 I, 8+k Gk for k<NGPR. Any other code drives all-ones (pull-up).
- XBUS destination by xdst, written on the next edge: 0 PC, 1 I, 2 T, 3 MAR, 4 WDR, 5 OPORT, 6/7 none, 8+k Gk for k<NGPR. Other codes: no write.
- rwr=1: R<=alu_result. fwr=1: FLG[3:1]<=alu_flag. FLG[0] and FLG[WIDTH-1:5] are always 0. FLG[4] is mem_err.
- errclr=1 clears mem_err. If errclr and a timeout occur in the same cycle, set wins.
- IPORT<=io_in every cycle (1-cycle sample latency).
- Memory FSM states IDLE, RD, WR:
  - mmrw=10 or 01 in IDLE: on the edge, capture mem_adrs<=MAR (value before any same-cycle MAR write). For writes also capture mem_wdata<=WDR. Set mem_req=1, set mem_we per op, counter<=0, move to RD or WR.
  - mmrw=00/11, or any mmrw while not IDLE: ignored, no queueing.
  - RD/WR with mem_ack=1: drop req, go to IDLE. A read also loads RDR<=mem_rdata on that edge.
  - RD/WR without ack: counter+1. When counter reaches MEM_TIMEOUT-1 with no ack, abort: drop req, set mem_err, go to IDLE. An aborted read loads RDR with all-ones.
  - mem_ack while IDLE is ignored.
  - An XBUS read of RDR during RD returns the old value.
  - Minimum read latency: issue edge + ack edge, so mem_busy is high for at least 1 cycle.
- resdt (combinational, no tri-state): 00 PC, 01 I, 02 T, 03 R, 04 MAR, 05 mem_rdata, 06 RDR, 07 WDR, 08 FLG, 09 XBUS, 0A IPORT, 0B FSM state (IDLE=0, RD=1, WR=2), 0C timeout counter, 10+k Gk. All other addresses return 0.

Test Plan:
- Reset then register moves, WIDTH=16, NGPR=4: xsrc=5,xdst=8 then xsrc=8,xdst=11 -> G0=G3=16'hFFFF, PC=0, resad=13 returns FFFF; xsrc=12 (no G4) reads FFFF.
- Read with ack on cycle 3 after issue, MAR=8'h40, mem_rdata=8'h5A -> mem_adrs=40, mem_req high 3 cycles, RDR=5A, mem_busy low next cycle.
- Write issued in the same cycle as a MAR<-8'h99 write, old MAR=8'h10, WDR=8'h3C -> mem_adrs=10, mem_wdata=3C, mem_we=1; a second mmrw=10 during WR is ignored.
- Timeout, MEM_TIMEOUT=4, no ack -> req drops after 4 cycles, RDR=FF, mem_err=1, FLG=8'h10; errclr -> FLG=0; errclr on the abort cycle leaves mem_err=1.
- ALU path: T=8'h01, xsrc=1 with R=8'h7F, alu_result=80, alu_flag=100, rwr=fwr=1 -> R=80, SZCy=100, FLG=08; alu_cy follows FLG[1].
- Reset asserted while in RD with ack pending -> next cycle mem_req=0, state=0, RDR=0; a late ack is ignored.
